// File: rtl/antic_dlist_fetch.sv
// antic_dlist_fetch: ANTIC display-list DMA fetcher with decoded-instruction FIFO (optional DLI via ANTIC_DLIST_DLI_EN)
// Ports: phi2/RST clock and sync reset; dma_en, vblank, dlist_load/dlist_base control the fetcher;
// DB/address/halt_L form the stolen-cycle memory read; instr_valid/instr_ready/instr_ir/instr_arg
// present the FIFO head; dlist_ptr and wait_vb expose fetcher state; dli_en/dli_req handle DLI.
module antic_dlist_fetch #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int PAGE_BITS  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              phi2,
  input  logic              RST,
  input  logic              dma_en,
  input  logic              vblank,
  input  logic              dlist_load,
  input  logic [ADDR_W-1:0] dlist_base,
  input  logic [DATA_W-1:0] DB,
  output logic [ADDR_W-1:0] address,
  output logic              halt_L,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_ir,
  output logic [ADDR_W-1:0] instr_arg,
  output logic [ADDR_W-1:0] dlist_ptr,
  output logic              wait_vb,
  input  logic              dli_en,
  output logic              dli_req
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_BITS) - 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH_IR, S_FETCH_LO, S_FETCH_HI, S_WAIT_VB} state_t;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_q_ir  [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_q_arg [FIFO_DEPTH];
  logic [PW-1:0]       r_rd;
  logic [PW-1:0]       r_wr;
  logic [CW-1:0]       r_cnt;
  logic                w_room;
  logic                w_fetch;
  logic                w_ir_ops;
  logic                w_jump;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_ptr_inc;
  logic [2*DATA_W-1:0] w_cat;
  logic [ADDR_W-1:0]   w_arg;
  logic [DATA_W-1:0]   w_push_ir;
  logic [ADDR_W-1:0]   w_push_arg;
  assign w_room     = r_cnt < CW'(FIFO_DEPTH);
  // operand bytes bypass the room check: the slot was reserved when the IR was issued
  assign w_fetch    = dma_en && !dlist_load &&
                      ((r_state == S_FETCH_IR && w_room) || r_state == S_FETCH_LO || r_state == S_FETCH_HI);
  assign w_ir_ops   = DB[3:0] == 4'd1 || (DB[3:0] >= 4'd2 && DB[6]);
  assign w_jump     = r_ir[3:0] == 4'd1;
  // only the low PAGE_BITS count; the upper pointer bits stay fixed
  assign w_ptr_inc  = (r_ptr & ~PAGE_MASK) | ((r_ptr + 1'b1) & PAGE_MASK);
  assign w_cat      = {DB, r_lo};
  assign w_arg      = w_cat[ADDR_W-1:0];
  assign w_push     = w_fetch && ((r_state == S_FETCH_IR && !w_ir_ops) || r_state == S_FETCH_HI);
  assign w_push_ir  = r_state == S_FETCH_HI ? r_ir : DB;
  assign w_push_arg = r_state == S_FETCH_HI ? w_arg : '0;
  assign w_pop      = instr_ready && r_cnt != '0;
  always_ff @(posedge phi2) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_ir    <= '0;
      r_lo    <= '0;
    end else if (dlist_load) begin
      r_ptr   <= dlist_base;
      r_state <= (r_state == S_IDLE || r_state == S_WAIT_VB) ? S_IDLE : S_FETCH_IR;
    end else begin
      case (r_state)
        S_IDLE, S_WAIT_VB: if (vblank) r_state <= S_FETCH_IR;
        S_FETCH_IR: if (w_fetch) begin
          r_ir  <= DB;
          r_ptr <= w_ptr_inc;
          if (w_ir_ops) r_state <= S_FETCH_LO;
        end
        S_FETCH_LO: if (w_fetch) begin
          r_lo    <= DB;
          r_ptr   <= w_ptr_inc;
          r_state <= S_FETCH_HI;
        end
        S_FETCH_HI: if (w_fetch) begin
          r_ptr   <= w_jump ? w_arg : w_ptr_inc;
          r_state <= (w_jump && r_ir[6]) ? S_WAIT_VB : S_FETCH_IR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge phi2) begin
    if (RST) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_q_ir[r_wr]  <= w_push_ir;
        r_q_arg[r_wr] <= w_push_arg;
        r_wr          <= r_wr == LAST ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd == LAST ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  assign address     = r_ptr;
  assign dlist_ptr   = r_ptr;
  assign halt_L      = !w_fetch;
  assign wait_vb     = r_state == S_WAIT_VB;
  assign instr_valid = r_cnt != '0;
  assign instr_ir    = instr_valid ? r_q_ir[r_rd] : '0;
  assign instr_arg   = instr_valid ? r_q_arg[r_rd] : '0;
`ifdef ANTIC_DLIST_DLI_EN
  logic r_dli;
  always_ff @(posedge phi2) r_dli <= RST ? 1'b0 : w_pop && dli_en && instr_ir[7];
  assign dli_req = r_dli;
`else
  logic w_unused_dli;
  assign w_unused_dli = dli_en;
  assign dli_req      = 1'b0;
`endif
endmodule

// File: tb/tb_antic_dlist_fetch.sv
// tb_antic_dlist_fetch: self-checking bench for antic_dlist_fetch (FIFO_DEPTH=2)
module tb_antic_dlist_fetch;
  localparam int DEPTH = 2;
`ifdef ANTIC_DLIST_DLI_EN
  localparam logic DLI = 1'b1;
`else
  localparam logic DLI = 1'b0;
`endif
  logic        phi2 = 1'b0;
  logic        RST, dma_en, vblank, dlist_load, instr_ready, dli_en;
  logic [15:0] dlist_base, address, instr_arg, dlist_ptr;
  logic [7:0]  DB, instr_ir;
  logic        halt_L, instr_valid, wait_vb, dli_req;
  logic [7:0]  mem [0:65535];
  int          errors = 0;
  int          checks = 0;
  antic_dlist_fetch #(.ADDR_W(16), .DATA_W(8), .PAGE_BITS(10), .FIFO_DEPTH(DEPTH)) dut (
    .phi2(phi2), .RST(RST), .dma_en(dma_en), .vblank(vblank), .dlist_load(dlist_load),
    .dlist_base(dlist_base), .DB(DB), .address(address), .halt_L(halt_L),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_ir(instr_ir),
    .instr_arg(instr_arg), .dlist_ptr(dlist_ptr), .wait_vb(wait_vb),
    .dli_en(dli_en), .dli_req(dli_req));
  assign DB = mem[address];
  always #5 phi2 = ~phi2;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  typedef struct {
    logic [15:0] base;
    logic [7:0]  ir, lo, hi;
    int          len;
    logic [15:0] arg, ptr;
    logic        wt;
  } vec_t;
  vec_t tv [12];
  function automatic logic [15:0] inc(input logic [15:0] p);
    return (p & 16'hFC00) | ((p + 16'd1) & 16'h03FF);
  endfunction
  function automatic bit has_ops(input logic [7:0] ir);
    return ir[3:0] == 4'd1 || (ir[3:0] >= 4'd2 && ir[6]);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge phi2);
    #1;
  endtask
  task automatic do_reset();
    RST = 1; dma_en = 0; vblank = 0; dlist_load = 0; instr_ready = 0; dli_en = 0; dlist_base = 0;
    tick();
    tick();
    RST = 0;
  endtask
  task automatic load(input logic [15:0] b);
    dlist_base = b;
    dlist_load = 1;
    tick();
    dlist_load = 0;
  endtask
  task automatic pulse_vb();
    vblank = 1;
    tick();
    vblank = 0;
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_address"}, address, 0);
    chk({nm, "_halt_L"}, halt_L, 1);
    chk({nm, "_valid"}, instr_valid, 0);
    chk({nm, "_ir"}, instr_ir, 0);
    chk({nm, "_arg"}, instr_arg, 0);
    chk({nm, "_ptr"}, dlist_ptr, 0);
    chk({nm, "_wait_vb"}, wait_vb, 0);
    chk({nm, "_dli_req"}, dli_req, 0);
  endtask
  task automatic pop_one(input logic [7:0] eir, input logic en, input logic exp);
    dli_en = en;
    @(negedge phi2);
    chk("dli_head_ir", instr_ir, eir);
    @(posedge phi2); #1;
    instr_ready = 1;
    @(posedge phi2); #1;
    instr_ready = 0;
    @(negedge phi2);
    chk("dli_req_pulse", dli_req, exp);
    @(negedge phi2);
    chk("dli_req_once", dli_req, 0);
  endtask
  initial begin
    int n, k, late, popped, target;
    logic [7:0]  gir [8];
    logic [15:0] garg [8];
    logic [7:0]  q_ir [$];
    logic [15:0] q_arg [$];
    logic [15:0] q_addr [$];
    logic [15:0] p, a;
    logic [7:0]  ir, lo, hi;
    tv[0]  = '{16'h1000, 8'h70, 8'h00, 8'h00, 1, 16'h0000, 16'h1001, 1'b0};
    tv[1]  = '{16'h1000, 8'h02, 8'h00, 8'h00, 1, 16'h0000, 16'h1001, 1'b0};
    tv[2]  = '{16'h1000, 8'h42, 8'h00, 8'h40, 3, 16'h4000, 16'h1003, 1'b0};
    tv[3]  = '{16'h1000, 8'h4F, 8'h34, 8'h12, 3, 16'h1234, 16'h1003, 1'b0};
    tv[4]  = '{16'h1000, 8'h0F, 8'h34, 8'h12, 1, 16'h0000, 16'h1001, 1'b0};
    tv[5]  = '{16'h1000, 8'h01, 8'h00, 8'h30, 3, 16'h3000, 16'h3000, 1'b0};
    tv[6]  = '{16'h1000, 8'h41, 8'h10, 8'h20, 3, 16'h2010, 16'h2010, 1'b1};
    tv[7]  = '{16'h1000, 8'h40, 8'hAA, 8'hBB, 1, 16'h0000, 16'h1001, 1'b0};
    tv[8]  = '{16'h1000, 8'h82, 8'h00, 8'h00, 1, 16'h0000, 16'h1001, 1'b0};
    tv[9]  = '{16'h1000, 8'hC5, 8'h11, 8'h22, 3, 16'h2211, 16'h1003, 1'b0};
    tv[10] = '{16'h23FF, 8'h02, 8'h00, 8'h00, 1, 16'h0000, 16'h2000, 1'b0};
    tv[11] = '{16'h23FE, 8'h42, 8'h34, 8'h12, 3, 16'h1234, 16'h2001, 1'b0};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    do_reset();
    @(negedge phi2);
    chk_reset_vals("reset");
    mem[16'h2000] = 8'h70; mem[16'h2001] = 8'h70; mem[16'h2002] = 8'h42;
    mem[16'h2003] = 8'h00; mem[16'h2004] = 8'h40;
    load(16'h2000);
    dma_en = 1;
    pulse_vb();
    tick();
    tick();
    tick();
    RST = 1;
    tick();
    tick();
    @(negedge phi2);
    chk_reset_vals("midreset");
    for (int v = 0; v < 12; v++) begin
      do_reset();
      mem[tv[v].base] = tv[v].ir;
      mem[inc(tv[v].base)] = tv[v].lo;
      mem[inc(inc(tv[v].base))] = tv[v].hi;
      load(tv[v].base);
      dma_en = 1;
      pulse_vb();
      n = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge phi2);
        if (instr_valid) break;
        if (!halt_L) n++;
        @(posedge phi2); #1;
      end
      chk($sformatf("vec%0d_valid", v), instr_valid, 1);
      chk($sformatf("vec%0d_ir", v), instr_ir, tv[v].ir);
      chk($sformatf("vec%0d_arg", v), instr_arg, tv[v].arg);
      chk($sformatf("vec%0d_len", v), n, tv[v].len);
      chk($sformatf("vec%0d_ptr", v), dlist_ptr, tv[v].ptr);
      chk($sformatf("vec%0d_wait_vb", v), wait_vb, tv[v].wt);
    end
    do_reset();
    mem[16'h2000] = 8'h70; mem[16'h2001] = 8'h70; mem[16'h2002] = 8'h42;
    mem[16'h2003] = 8'h00; mem[16'h2004] = 8'h40;
    load(16'h2000);
    dma_en = 1;
    instr_ready = 1;
    pulse_vb();
    n = 0;
    k = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge phi2);
      if (!halt_L) n++;
      if (instr_valid && k < 8) begin
        gir[k] = instr_ir;
        garg[k] = instr_arg;
        k++;
      end
      @(posedge phi2); #1;
      if (n == 5) dma_en = 0;
    end
    chk("basic_fetches", n, 5);
    chk("basic_entries", k, 3);
    chk("basic_e0_ir", gir[0], 8'h70);
    chk("basic_e0_arg", garg[0], 16'h0000);
    chk("basic_e1_ir", gir[1], 8'h70);
    chk("basic_e2_ir", gir[2], 8'h42);
    chk("basic_e2_arg", garg[2], 16'h4000);
    chk("basic_ptr", dlist_ptr, 16'h2005);
    do_reset();
    mem[16'h2010] = 8'h41; mem[16'h2011] = 8'h00; mem[16'h2012] = 8'h20;
    load(16'h2010);
    dma_en = 1;
    instr_ready = 1;
    pulse_vb();
    n = 0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge phi2);
      if (!halt_L) n++;
      if (instr_valid && k < 8) begin
        gir[k] = instr_ir;
        garg[k] = instr_arg;
        k++;
      end
      @(posedge phi2); #1;
    end
    chk("jvb_fetches", n, 3);
    chk("jvb_entries", k, 1);
    chk("jvb_ir", gir[0], 8'h41);
    chk("jvb_arg", garg[0], 16'h2000);
    @(negedge phi2);
    chk("jvb_wait_vb", wait_vb, 1);
    chk("jvb_ptr", dlist_ptr, 16'h2000);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge phi2);
      if (!halt_L) n++;
    end
    chk("jvb_parked_fetches", n, 0);
    @(posedge phi2); #1;
    pulse_vb();
    @(negedge phi2);
    chk("jvb_resume_halt", halt_L, 0);
    chk("jvb_resume_addr", address, 16'h2000);
    do_reset();
    for (int i = 0; i < 5; i++) mem[16'h2100 + i] = 8'h02;
    load(16'h2100);
    dma_en = 1;
    pulse_vb();
    n = 0;
    late = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge phi2);
      if (!halt_L) n++;
      if (!halt_L && c >= 10) late++;
      @(posedge phi2); #1;
    end
    chk("bp_fetches", n, DEPTH);
    chk("bp_idle_20", late, 0);
    chk("bp_valid", instr_valid, 1);
    instr_ready = 1;
    @(negedge phi2);
    chk("bp_pop_cycle_halt", halt_L, 1);
    @(posedge phi2); #1;
    instr_ready = 0;
    @(negedge phi2);
    chk("bp_refill_halt", halt_L, 0);
    chk("bp_refill_addr", address, 16'h2102);
    @(negedge phi2);
    chk("bp_after_refill_halt", halt_L, 1);
    do_reset();
    mem[16'h2200] = 8'h82; mem[16'h2201] = 8'h02; mem[16'h2202] = 8'h82; mem[16'h2203] = 8'h02;
    load(16'h2200);
    dma_en = 1;
    pulse_vb();
    for (int c = 0; c < 6; c++) tick();
    pop_one(8'h82, 1'b1, DLI);
    pop_one(8'h02, 1'b1, 1'b0);
    pop_one(8'h82, 1'b0, 1'b0);
    do_reset();
    mem[16'h2300] = 8'h42; mem[16'h2301] = 8'h11; mem[16'h2302] = 8'h22;
    mem[16'h2400] = 8'h02; mem[16'h2401] = 8'h02;
    load(16'h2300);
    dma_en = 1;
    pulse_vb();
    tick();
    tick();
    load(16'h2400);
    @(negedge phi2);
    chk("reload_addr", address, 16'h2400);
    chk("reload_halt", halt_L, 0);
    tick();
    @(negedge phi2);
    chk("reload_valid", instr_valid, 1);
    chk("reload_head_ir", instr_ir, 8'h02);
    chk("reload_head_arg", instr_arg, 16'h0000);
    for (int it = 0; it < 4; it++) begin
      do_reset();
      q_ir.delete();
      q_arg.delete();
      q_addr.delete();
      p = 16'($urandom);
      a = p;
      for (int i = 0; i < 40; i++) begin
        ir = mem[p];
        q_addr.push_back(p);
        p = inc(p);
        a = 16'h0000;
        if (has_ops(ir)) begin
          q_addr.push_back(p);
          lo = mem[p];
          p = inc(p);
          q_addr.push_back(p);
          hi = mem[p];
          p = inc(p);
          a = {hi, lo};
          if (ir[3:0] == 4'd1) p = a;
        end
        q_ir.push_back(ir);
        q_arg.push_back(a);
        if (ir[3:0] == 4'd1 && ir[6]) break;
      end
      target = q_ir.size() < 12 ? q_ir.size() : 12;
      popped = 0;
      load(q_addr[0]);
      dma_en = 1;
      pulse_vb();
      for (int c = 0; c < 400 && popped < target; c++) begin
        @(negedge phi2);
        if (!halt_L) begin
          if (q_addr.size() > 0) chk("rnd_addr", address, q_addr.pop_front());
          else chk("rnd_extra_fetch", 1, 0);
        end
        if (instr_valid && instr_ready) begin
          chk("rnd_ir", instr_ir, q_ir.pop_front());
          chk("rnd_arg", instr_arg, q_arg.pop_front());
          popped++;
        end
        @(posedge phi2); #1;
        dma_en = $urandom_range(0, 3) != 0;
        instr_ready = popped < target && $urandom_range(0, 1) == 1;
      end
      chk("rnd_popped", popped, target);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
